// File: rtl/sfo_search_scheduler_pkg.sv
// Shared constants, types and FSM encoding for the SFO hypothesis sweep.
// Hypothesis widths are the mrr_params.vh values.
package sfo_search_scheduler_pkg;
    localparam int FFT_LEN_LOG2   = 9;
    localparam int SFO_INT_WIDTH  = 8;
    localparam int SFO_FRAC_WIDTH = 8;
    localparam int SFO_WIDTH      = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
    localparam int CORR_WIDTH     = 26;
    localparam int HYP_CNT_WIDTH  = 8;
    localparam int TIMEOUT_WIDTH  = 8;

    typedef logic [SFO_WIDTH-1:0]     sfo_t;
    typedef logic [CORR_WIDTH-1:0]    corr_t;
    typedef logic [HYP_CNT_WIDTH-1:0] hyp_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_WAIT_RESULT,
        S_COMPARE,
        S_DONE
    } state_t;
endpackage

// File: rtl/sfo_search_scheduler_if.sv
// Scheduler <-> magnitude RAM / correlator bundle.
// master: the scheduler; slave: the RAM and correlator side.
interface sfo_search_scheduler_if;
    import sfo_search_scheduler_pkg::*;

    logic                      fft_rd_en;
    logic [FFT_LEN_LOG2-1:0]   fft_rd_addr;
    logic [SFO_INT_WIDTH-1:0]  corr_sfo_int;
    logic [SFO_FRAC_WIDTH-1:0] corr_sfo_frac;
    logic                      corr_reset;
    logic                      corr_update;
    corr_t                     corr_result;
    logic                      corr_result_valid;

    modport master (
        output fft_rd_en, fft_rd_addr, corr_sfo_int, corr_sfo_frac,
        output corr_reset, corr_update,
        input  corr_result, corr_result_valid
    );

    modport slave (
        input  fft_rd_en, fft_rd_addr, corr_sfo_int, corr_sfo_frac,
        input  corr_reset, corr_update,
        output corr_result, corr_result_valid
    );
endinterface

// File: rtl/sfo_search_scheduler_hyp_stepper.sv
// Hypothesis register, modular step adder and index counter.
// last flags the final hypothesis; a count of 0 behaves as 1.
module sfo_hyp_stepper
    import sfo_search_scheduler_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     advance,
    input  sfo_t     start_sfo,
    input  sfo_t     step_sfo,
    input  hyp_idx_t num_hyp,
    output sfo_t     hyp,
    output hyp_idx_t idx,
    output logic     last
);
    sfo_t     step;
    hyp_idx_t last_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hyp      <= '0;
            idx      <= '0;
            step     <= '0;
            last_idx <= '0;
        end else if (load) begin
            hyp      <= start_sfo;
            idx      <= '0;
            step     <= step_sfo;
            last_idx <= (num_hyp == '0) ? '0 : num_hyp - HYP_CNT_WIDTH'(1);
        end else if (advance) begin
            hyp <= hyp + step;
            idx <= idx + HYP_CNT_WIDTH'(1);
        end
    end

    assign last = (idx == last_idx);
endmodule

// File: rtl/sfo_search_scheduler.sv
// Sweeps SFO hypotheses through the FFT correlator and keeps the best
// correlation seen for one CFO's magnitude buffer.
module sfo_search_scheduler
    import sfo_search_scheduler_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  sfo_t                     cfg_sfo_start,
    input  sfo_t                     cfg_sfo_step,
    input  hyp_idx_t                 cfg_num_hyp,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    sfo_search_scheduler_if.master   bus,
    output sfo_t                     best_sfo,
    output corr_t                    best_corr,
    output hyp_idx_t                 best_index,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);
    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] timeout_cfg;
    logic [TIMEOUT_WIDTH-1:0] timer;
    corr_t                    result;
    logic                     rd_en;
    logic                     update;
    logic                     corr_rst_q;
    logic [FFT_LEN_LOG2-1:0]  addr;
    sfo_t                     hyp;
    hyp_idx_t                 idx;
    logic                     last;
    logic                     load;
    logic                     advance;

    assign load    = (state == S_IDLE) && start;
    assign advance = (state == S_COMPARE) && !last && !abort;

    sfo_hyp_stepper u_stepper (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
        .start_sfo (cfg_sfo_start),
        .step_sfo  (cfg_sfo_step),
        .num_hyp   (cfg_num_hyp),
        .hyp       (hyp),
        .idx       (idx),
        .last      (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timeout_cfg <= '0;
            timer       <= '0;
            result      <= '0;
            rd_en       <= 1'b0;
            update      <= 1'b0;
            corr_rst_q  <= 1'b0;
            addr        <= '0;
            best_sfo    <= '0;
            best_corr   <= '0;
            best_index  <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done       <= 1'b0;
            corr_rst_q <= 1'b0;
            update     <= rd_en;
            if (abort && state != S_IDLE) begin
                state      <= S_IDLE;
                corr_rst_q <= 1'b1;
                rd_en      <= 1'b0;
                update     <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: if (start) begin
                        timeout_cfg <= cfg_timeout;
                        best_sfo    <= '0;
                        best_corr   <= '0;
                        best_index  <= '0;
                        timeout_err <= 1'b0;
                        corr_rst_q  <= 1'b1;
                        state       <= S_LOAD;
                    end
                    S_LOAD: begin
                        rd_en <= 1'b1;
                        addr  <= '0;
                        state <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (addr == '1) begin
                            rd_en <= 1'b0;
                            state <= S_DRAIN;
                        end else begin
                            addr <= addr + FFT_LEN_LOG2'(1);
                        end
                    end
                    S_DRAIN: begin
                        timer <= timeout_cfg;
                        state <= S_WAIT_RESULT;
                    end
                    // A valid arriving in the expiry cycle still wins.
                    S_WAIT_RESULT: begin
                        if (bus.corr_result_valid) begin
                            result <= bus.corr_result;
                            state  <= S_COMPARE;
                        end else if (timer <= TIMEOUT_WIDTH'(1)) begin
                            result      <= '0;
                            timeout_err <= 1'b1;
                            state       <= S_COMPARE;
                        end else begin
                            timer <= timer - TIMEOUT_WIDTH'(1);
                        end
                    end
                    S_COMPARE: begin
                        if (idx == '0 || result > best_corr) begin
                            best_corr  <= result;
                            best_sfo   <= hyp;
                            best_index <= idx;
                        end
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            corr_rst_q <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy              = (state != S_IDLE);
    assign bus.fft_rd_en     = rd_en;
    assign bus.fft_rd_addr   = addr;
    assign bus.corr_update   = update;
    assign bus.corr_reset    = corr_rst_q | reset;
    assign bus.corr_sfo_int  = hyp[SFO_WIDTH-1:SFO_FRAC_WIDTH];
    assign bus.corr_sfo_frac = hyp[SFO_FRAC_WIDTH-1:0];
endmodule

// File: tb/tb_sfo_search_scheduler.sv
// Self-checking bench: behavioural correlator/RAM model plus a sweep-level
// reference for best result, timeout and cycle count.
module tb_sfo_search_scheduler;
    localparam int N = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_sfo_start = '0;
    logic [15:0] cfg_sfo_step = '0;
    logic [7:0]  cfg_num_hyp = '0;
    logic [7:0]  cfg_timeout = '0;
    logic [15:0] best_sfo;
    logic [25:0] best_corr;
    logic [7:0]  best_index;
    logic        busy, done, timeout_err;

    sfo_search_scheduler_if bus ();

    sfo_search_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_sfo_start (cfg_sfo_start),
        .cfg_sfo_step  (cfg_sfo_step),
        .cfg_num_hyp   (cfg_num_hyp),
        .cfg_timeout   (cfg_timeout),
        .bus           (bus),
        .best_sfo      (best_sfo),
        .best_corr     (best_corr),
        .best_index    (best_index),
        .busy          (busy),
        .done          (done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-hypothesis correlator behaviour; tdiv < 0 means never valid.
    int res_q [16];
    int tdiv_q [16];
    logic [15:0] m_start, m_step;

    int cyc = 0, busy_cyc = 0, done_cnt = 0, rst_cnt = 0, upd_cnt = 0;
    int upd_h = 0, align_err = 0, sfo_err = 0, addr_err = 0;
    int drain_cyc = -1, terr_cyc = -1, ctr = -1, cur = 0, exp_addr = 0;
    int result_m = 0;
    bit prev_rd = 0, valid_m = 0;

    assign bus.corr_result       = 26'(result_m);
    assign bus.corr_result_valid = valid_m;

    function automatic logic [15:0] exp_sfo(input int k);
        logic [31:0] t;
        t = 32'(m_start) + 32'(k) * 32'(m_step);
        return t[15:0];
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            valid_m = 0;
            ctr     = -1;
            prev_rd = 0;
        end else begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (timeout_err && terr_cyc < 0) terr_cyc = cyc;
            if (!bus.corr_reset && bus.corr_update != prev_rd) align_err++;
            if (bus.fft_rd_en) begin
                if (int'(bus.fft_rd_addr) != exp_addr) addr_err++;
                exp_addr++;
            end
            if (bus.corr_reset) begin
                cur = rst_cnt & 15;
                rst_cnt++;
                upd_h    = 0;
                valid_m  = 0;
                ctr      = -1;
                exp_addr = 0;
            end else if (bus.corr_update) begin
                upd_cnt++;
                upd_h++;
                if ({bus.corr_sfo_int, bus.corr_sfo_frac} != exp_sfo(cur))
                    sfo_err++;
                if (upd_h == N) begin
                    if (drain_cyc < 0) drain_cyc = cyc;
                    ctr = tdiv_q[cur];
                end
            end else if (ctr > 0) begin
                ctr--;
                if (ctr == 0) begin
                    valid_m  = 1;
                    result_m = res_q[cur];
                end
            end
            prev_rd = bus.fft_rd_en;
        end
    end

    task automatic clear_counts();
        busy_cyc = 0; done_cnt = 0; rst_cnt = 0; upd_cnt = 0;
        align_err = 0; addr_err = 0; sfo_err = 0;
        drain_cyc = -1; terr_cyc = -1;
    endtask

    task automatic kick(input logic [15:0] s, input logic [15:0] st,
                        input int nh, input int to);
        m_start = s;
        m_step  = st;
        @(negedge clk); #1;
        clear_counts();
        cfg_sfo_start = s;
        cfg_sfo_step  = st;
        cfg_num_hyp   = 8'(nh);
        cfg_timeout   = 8'(to);
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input string tag, input logic [15:0] s,
                             input logic [15:0] st, input int nh,
                             input int to, input bit inject);
        int nh_eff, teff, best, bidx, cycles;
        bit terr;
        kick(s, st, nh, to);
        for (int c = 0; c < 30000 && done_cnt == 0; c++) begin
            if (inject && c == 40) begin
                cfg_num_hyp   = 8'd3;
                cfg_sfo_start = ~s;
                cfg_sfo_step  = 16'h0101;
                cfg_timeout   = 8'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); #1;
        end
        start = 1'b0;
        if (done_cnt == 0) check({tag, "_bound"}, 0, 1);
        @(negedge clk); #1;

        nh_eff = (nh == 0) ? 1 : nh;
        teff   = (to == 0) ? 1 : to;
        best = 0; bidx = 0; cycles = 1; terr = 0;
        for (int k = 0; k < nh_eff; k++) begin
            int r, w;
            if (tdiv_q[k] >= 1 && tdiv_q[k] <= teff) begin
                r = res_q[k];
                w = tdiv_q[k];
            end else begin
                r = 0;
                w = teff;
                terr = 1;
            end
            cycles += 1 + N + 1 + w + 1;
            if (k == 0 || r > best) begin
                best = r;
                bidx = k;
            end
        end
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_resets"}, rst_cnt, nh_eff);
        check({tag, "_updates"}, upd_cnt, N * nh_eff);
        check({tag, "_align"}, align_err, 0);
        check({tag, "_addr"}, addr_err, 0);
        check({tag, "_sfo_out"}, sfo_err, 0);
        check({tag, "_cycles"}, busy_cyc, cycles);
        check({tag, "_best_corr"}, best_corr, best);
        check({tag, "_best_index"}, best_index, bidx);
        check({tag, "_best_sfo"}, best_sfo, exp_sfo(bidx));
        check({tag, "_timeout_err"}, timeout_err, terr);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bit found;
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_corr_reset_high", bus.corr_reset, 1);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_corr_reset_low", bus.corr_reset, 0);
        check("rst_outs", {done, timeout_err, bus.fft_rd_en, bus.corr_update}, 0);
        check("rst_best", {best_sfo, best_index}, 0);
        check("rst_best_corr", best_corr, 0);
        check("rst_sfo", {bus.corr_sfo_int, bus.corr_sfo_frac}, 0);

        // Single hypothesis
        res_q[0] = 7; tdiv_q[0] = 4;
        run_sweep("one", 16'h0100, 16'h0000, 1, 20, 0);

        // Ties keep the earlier index
        res_q[0] = 5; res_q[1] = 9; res_q[2] = 9; res_q[3] = 3;
        tdiv_q[0] = 3; tdiv_q[1] = 5; tdiv_q[2] = 2; tdiv_q[3] = 7;
        run_sweep("four", 16'h0300, 16'h0040, 4, 20, 0);

        // Result never valid
        tdiv_q[0] = -1; tdiv_q[1] = -1;
        res_q[0] = 77; res_q[1] = 88;
        run_sweep("tmo", 16'h0500, 16'h0001, 2, 10, 0);
        check("tmo_wait_len", terr_cyc - drain_cyc, 11);

        // Second start ignored; num_hyp=0 runs one; valid ties with expiry
        res_q[0] = 42; tdiv_q[0] = 15;
        run_sweep("busy_start", 16'h0A00, 16'h0111, 0, 15, 1);

        // Abort mid-stream
        for (int k = 0; k < 16; k++) begin res_q[k] = 3; tdiv_q[k] = 3; end
        kick(16'h0200, 16'h0010, 4, 20);
        found = 0;
        for (int c = 0; c < 2000 && !found; c++) begin
            if (bus.fft_rd_en && bus.fft_rd_addr == 9'd100) found = 1;
            else begin @(negedge clk); #1; end
        end
        check("abort_reach", found, 1);
        abort = 1'b1;
        @(negedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_corr_reset", bus.corr_reset, 1);
        check("abort_rd_upd", {bus.fft_rd_en, bus.corr_update}, 0);
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_rst_pulses", rst_cnt, 2);
        check("abort_idle", {busy, bus.corr_reset}, 0);

        // Async reset while waiting for a result
        tdiv_q[0] = -1;
        kick(16'h1234, 16'h0000, 1, 60);
        for (int c = 0; c < 2000 && drain_cyc < 0; c++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
        check("ar_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_sfo", {bus.corr_sfo_int, bus.corr_sfo_frac}, 0);
        check("ar_outs", {done, timeout_err, bus.fft_rd_en, bus.corr_update}, 0);
        check("ar_corr_reset", bus.corr_reset, 1);
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("ar_after", {busy, bus.corr_reset}, 0);

        // Randomized sweeps
        for (int it = 0; it < 6; it++) begin
            int nh, to;
            nh = $urandom_range(0, 5);
            to = $urandom_range(2, 24);
            for (int k = 0; k < 16; k++) begin
                int r;
                r = $urandom_range(0, 3);
                res_q[k]  = $urandom_range(0, 15);
                tdiv_q[k] = (r == 0) ? -1 : (r == 1) ? to : $urandom_range(1, to);
            end
            run_sweep($sformatf("rnd%0d", it), 16'($urandom), 16'($urandom), nh, to, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
